// File: rtl/nes_pad_reader.sv
// Frame-synchronous NES gamepad poller: latches the pad, shifts out eight buttons,
// and presents them as registered active-high levels with opposing directions cleaned.
module nes_pad_reader #(
    parameter int LATCH_CYCLES = 144,
    parameter int HALF_CYCLES  = 72
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_rate,
    input  logic nes_data,
    output logic nes_latch,
    output logic nes_clk,
    output logic button_a,
    output logic button_b,
    output logic button_select,
    output logic button_start,
    output logic button_up,
    output logic button_down,
    output logic button_left,
    output logic button_right,
    output logic buttons_valid
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        COMMIT
    } state_t;

    localparam logic [11:0] LATCH_LAST = 12'(LATCH_CYCLES - 1);
    localparam logic [11:0] HALF_LAST  = 12'(HALF_CYCLES - 1);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  buttons_q, buttons_d;
    logic [1:0]  sync_q, sync_d;
    logic        valid_q, valid_d;
    logic        latch_q, latch_d;
    logic        nclk_q, nclk_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        sync_d    = {sync_q[0], nes_data};

        case (state_q)
            IDLE: begin
                if (frame_rate) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            LOW: begin
                if (cnt_q == HALF_LAST) begin
                    shift_d[idx_q] = ~sync_q[1];
                    cnt_d          = '0;
                    state_d        = (idx_q == 3'd7) ? COMMIT : HIGH;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            COMMIT: begin
                // Opposing directions pressed together cancel to neither.
                buttons_d[3:0] = shift_q[3:0];
                buttons_d[5:4] = (shift_q[4] & shift_q[5]) ? 2'b00 : shift_q[5:4];
                buttons_d[7:6] = (shift_q[6] & shift_q[7]) ? 2'b00 : shift_q[7:6];
                valid_d        = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        latch_d = (state_d == LATCH);
        nclk_d  = (state_d == HIGH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            sync_q    <= '0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            sync_q    <= sync_d;
            valid_q   <= valid_d;
            latch_q   <= latch_d;
            nclk_q    <= nclk_d;
        end
    end

    assign nes_latch     = latch_q;
    assign nes_clk       = nclk_q;
    assign buttons_valid = valid_q;
    assign button_a      = buttons_q[0];
    assign button_b      = buttons_q[1];
    assign button_select = buttons_q[2];
    assign button_start  = buttons_q[3];
    assign button_up     = buttons_q[4];
    assign button_down   = buttons_q[5];
    assign button_left   = buttons_q[6];
    assign button_right  = buttons_q[7];

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader: two instances (default and short timing), each
// driven by a behavioural pad shift register, checked with immediate assertions.
module tb_nes_pad_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  frame_rate;
    logic [1:0]  nes_data;
    logic [1:0]  nes_latch;
    logic [1:0]  nes_clk;
    logic [1:0]  valid;
    logic [15:0] btn;
    logic [7:0]  pad_press [2];
    logic [7:0]  pad_sr [2];
    logic [1:0]  nclk_prev;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    nes_pad_reader u_dut0 (
        .clk(clk), .reset(reset), .frame_rate(frame_rate[0]), .nes_data(nes_data[0]),
        .nes_latch(nes_latch[0]), .nes_clk(nes_clk[0]),
        .button_a(btn[0]), .button_b(btn[1]), .button_select(btn[2]), .button_start(btn[3]),
        .button_up(btn[4]), .button_down(btn[5]), .button_left(btn[6]), .button_right(btn[7]),
        .buttons_valid(valid[0])
    );

    nes_pad_reader #(.LATCH_CYCLES(2), .HALF_CYCLES(4)) u_dut1 (
        .clk(clk), .reset(reset), .frame_rate(frame_rate[1]), .nes_data(nes_data[1]),
        .nes_latch(nes_latch[1]), .nes_clk(nes_clk[1]),
        .button_a(btn[8]), .button_b(btn[9]), .button_select(btn[10]), .button_start(btn[11]),
        .button_up(btn[12]), .button_down(btn[13]), .button_left(btn[14]), .button_right(btn[15]),
        .buttons_valid(valid[1])
    );

    assign nes_data = {pad_sr[1][0], pad_sr[0][0]};

    // Pad model: parallel load while latched, shift toward the data pin on each nes_clk rise.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                pad_sr[i] <= 8'hFF;
            end else if (nes_latch[i]) begin
                pad_sr[i] <= ~pad_press[i];
            end else if (nes_clk[i] && !nclk_prev[i]) begin
                pad_sr[i] <= {1'b1, pad_sr[i][7:1]};
            end
            nclk_prev[i] <= nes_clk[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] buttonsOf(input int sel);
        return (sel == 1) ? btn[15:8] : btn[7:0];
    endfunction

    // One full poll on instance sel; tick_at is an extra frame_rate edge during the poll (-1 = none).
    task automatic applyStimulus(input int sel, input logic [7:0] press, input logic [7:0] exp,
                                 input int tick_at, input string tag);
        int   l_cyc;
        int   h_cyc;
        int   commit;
        int   latch_cnt;
        int   rises;
        int   valid_early;
        int   last_edge;
        logic phase_ok;
        logic prev_nclk;
        logic prev_latch;
        l_cyc       = (sel == 1) ? 2 : 144;
        h_cyc       = (sel == 1) ? 4 : 72;
        commit      = 1 + l_cyc + 15 * h_cyc;
        latch_cnt   = 0;
        rises       = 0;
        valid_early = 0;
        last_edge   = 0;
        phase_ok    = 1'b1;
        prev_nclk   = 1'b0;
        prev_latch  = 1'b0;
        pad_press[sel] = press;
        @(negedge clk);
        frame_rate[sel] = 1'b1;
        for (int c = 0; c <= commit; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) frame_rate[sel] = 1'b0;
            if (c == tick_at - 1) frame_rate[sel] = 1'b1;
            if (c == tick_at) frame_rate[sel] = 1'b0;
            if (nes_latch[sel]) latch_cnt++;
            if (prev_latch && !nes_latch[sel]) last_edge = c;
            if (nes_clk[sel] != prev_nclk) begin
                if (c - last_edge != h_cyc) phase_ok = 1'b0;
                last_edge = c;
                if (nes_clk[sel]) rises++;
            end
            if (valid[sel] && c != commit) valid_early++;
            prev_latch = nes_latch[sel];
            prev_nclk  = nes_clk[sel];
        end
        checkOutput({tag, "/latch_len"}, 16'(latch_cnt), 16'(l_cyc));
        checkOutput({tag, "/clk_pulses"}, 16'(rises), 16'd7);
        checkOutput({tag, "/phase_len"}, {15'd0, phase_ok}, 16'd1);
        checkOutput({tag, "/valid_early"}, 16'(valid_early), 16'd0);
        checkOutput({tag, "/valid_commit"}, {15'd0, valid[sel]}, 16'd1);
        checkOutput({tag, "/buttons"}, {8'd0, buttonsOf(sel)}, {8'd0, exp});
        @(posedge clk);
        #1;
        checkOutput({tag, "/valid_pulse"}, {15'd0, valid[sel]}, 16'd0);
        checkOutput({tag, "/hold"}, {8'd0, buttonsOf(sel)}, {8'd0, exp});
    endtask

    initial begin
        int bad;
        reset        = 1'b0;
        frame_rate   = 2'b00;
        pad_press[0] = 8'h00;
        pad_press[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset/latch", {14'd0, nes_latch}, 16'd0);
        checkOutput("reset/nes_clk", {14'd0, nes_clk}, 16'd0);
        checkOutput("reset/valid", {14'd0, valid}, 16'd0);
        checkOutput("reset/buttons", btn, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        applyStimulus(0, 8'h80, 8'h80, -1, "right_only");
        applyStimulus(0, 8'h29, 8'h29, -1, "a_start_down");
        applyStimulus(0, 8'hD0, 8'h10, -1, "clean_lr");
        applyStimulus(0, 8'h32, 8'h02, -1, "clean_ud");

        // Abort a poll partway through a HIGH phase with buttons still showing B.
        pad_press[0] = 8'h01;
        @(negedge clk);
        frame_rate[0] = 1'b1;
        @(posedge clk);
        #1;
        frame_rate[0] = 1'b0;
        repeat (230) @(posedge clk);
        #1;
        checkOutput("midpoll/nes_clk_high", {15'd0, nes_clk[0]}, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midpoll/latch", {15'd0, nes_latch[0]}, 16'd0);
        checkOutput("midpoll/nes_clk", {15'd0, nes_clk[0]}, 16'd0);
        checkOutput("midpoll/buttons", {8'd0, btn[7:0]}, 16'd0);
        checkOutput("midpoll/valid", {15'd0, valid[0]}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 1400; c++) begin
            @(posedge clk);
            #1;
            if (valid[0] || nes_latch[0] || nes_clk[0]) bad++;
        end
        checkOutput("midpoll/stays_idle", 16'(bad), 16'd0);

        applyStimulus(0, 8'h01, 8'h01, 500, "tick_in_poll");
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (valid[0] || nes_latch[0]) bad++;
        end
        checkOutput("tick_in_poll/no_restart", 16'(bad), 16'd0);

        pad_press[0] = 8'h00;
        repeat (50) @(posedge clk);
        #1;
        checkOutput("hold/keep_a", {8'd0, btn[7:0]}, 16'h0001);
        applyStimulus(0, 8'h00, 8'h00, -1, "hold/release");

        applyStimulus(1, 8'h01, 8'h01, -1, "short/a");
        pad_press[1] = 8'h00;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("short/keep_a", {8'd0, btn[15:8]}, 16'h0001);
        applyStimulus(1, 8'h00, 8'h00, -1, "short/release");
        applyStimulus(1, 8'hC8, 8'h08, -1, "short/start_lr");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Polls one NES-style serial gamepad once per game frame, deserialises its 8 button bits, and presents them as registered, active-high button levels. It sits directly upstream of the per-player movement state machine, feeding its `button_up/down/left/right` inputs. Opposing directions are cleaned so the movement logic never sees both held at once. One instance per player.

## Interface
- `LATCH_CYCLES`, default 144: `nes_latch` high time in `clk` cycles (12 us at 12 MHz); legal 2..4095.
- `HALF_CYCLES`, default 72: each `nes_clk` low and high phase in `clk` cycles (6 us); legal 4..4095.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `frame_rate`  in  1  one-cycle frame tick, the same tick the movement logic uses; starts a poll.
- `nes_data`  in  1  serial data from pad; active-low (0 = pressed); asynchronous to `clk`.
- `nes_latch`  out  1  parallel-load strobe to pad.
- `nes_clk`  out  1  shift clock to pad; idles low; pad shifts on its rising edge.
- `button_a`, `button_b`, `button_select`, `button_start`  out  1 each  active-high, registered.
- `button_up`, `button_down`, `button_left`, `button_right`  out  1 each  active-high, registered, direction-cleaned.
- `buttons_valid`  out  1  one-cycle pulse coincident with a button update.

## Operation
- `nes_data` passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- States: IDLE, LATCH, LOW, HIGH, COMMIT.
- IDLE: `nes_latch`=0, `nes_clk`=0. `frame_rate`=1 -> LATCH, phase counter = 0, bit index = 0.
- LATCH: `nes_latch`=1 for exactly `LATCH_CYCLES` cycles -> LOW.
- LOW: `nes_clk`=0 for `HALF_CYCLES` cycles. On the last cycle, shift the inverted synchronised data into `shift[idx]`. If idx = 7 -> COMMIT, else -> HIGH.
- HIGH: `nes_clk`=1 for `HALF_CYCLES` cycles; idx += 1 -> LOW.
- Bit order is idx 0..7: A, B, Select, Start, Up, Down, Left, Right.
- COMMIT, one cycle: all eight outputs load together from `shift`, `buttons_valid`=1 -> IDLE. Outputs never show a partially read frame.
- Direction cleaning, applied at COMMIT:
  - Left and Right both pressed -> both outputs 0.
  - Up and Down both pressed -> both outputs 0.
  - A, B, Select and Start are never masked.
- `frame_rate` outside IDLE is ignored: no queueing, no restart.
- Counters are 12-bit and compare against `PARAM-1`; there is no wrap path.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE
  - `nes_latch`=0, `nes_clk`=0
  - all buttons 0, `buttons_valid`=0
  - shift register and synchroniser 0
- Reset mid-poll aborts immediately and applies the same values. The next poll starts clean on the next `frame_rate`.
- Cycle numbering: `frame_rate` sampled high at edge 0.
  - `nes_latch` high for cycles 1..L, where L = `LATCH_CYCLES`.
  - bit k sampled at cycle L + (2k+1)·H, where H = `HALF_CYCLES`.
  - update plus `buttons_valid` at cycle 1 + L + 15·H. With defaults this is 1225.
- Outputs hold their values between `buttons_valid` pulses.
- A poll (1225 cycles) is far shorter than a frame (200 000 cycles at 60 Hz).
- Pad data must settle within H−2 cycles of a `nes_clk` rising edge or the fall of `nes_latch`; this allows for synchroniser latency.

## Test plan
- Reset then idle: `reset`=0 mid-HIGH phase -> `nes_latch`=0, `nes_clk`=0 and all outputs 0 immediately. No `buttons_valid` until a new `frame_rate`.
- Single poll, defaults: bench pad model (8-bit parallel-in shift register) holds only Right pressed -> `button_right`=1 and all others 0 at cycle 1225 with `buttons_valid`=1. The bench checks exactly 7 `nes_clk` pulses, each 72 high / 72 low, and a 144-cycle latch.
- Bit ordering: pad pattern A, Start, Down pressed -> `button_a`=1, `button_start`=1, `button_down`=1 and all others 0.
- Direction cleaning: Left+Right+Up pressed -> `button_left`=0, `button_right`=0, `button_up`=1. Up+Down+B pressed -> `button_up`=0, `button_down`=0, `button_b`=1.
- Tick during poll: second `frame_rate` at cycle 500 -> ignored. Exactly one `buttons_valid` at cycle 1225, and the next poll starts only on a later tick.
- Hold and change: pad changes from A to none mid-frame, after sampling -> outputs keep A=1 until the next poll commits A=0. Repeat with `LATCH_CYCLES`=2 and `HALF_CYCLES`=4: commit at cycle 63.
